// File: rtl/rns_mod_add_acc.sv
// Multi-channel two-stage modular adder/accumulator for the RNS datapath.
// Each channel reduces a+b (or acc+a) modulo its own modulus and flags wrap / out-of-range operands.
module rns_mod_add_acc #(
  parameter int DATA_WIDTH = 18,
  parameter int NUM_CH     = 4,
  parameter logic [NUM_CH*(DATA_WIDTH+1)-1:0] MODULI =
    {19'd161051, 19'd130321, 19'd262144, 19'd177147}
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic                         op_mode,
  input  logic                         acc_clr,
  input  logic [NUM_CH*DATA_WIDTH-1:0] a,
  input  logic [NUM_CH*DATA_WIDTH-1:0] b,
  output logic                         out_valid,
  output logic [NUM_CH*DATA_WIDTH-1:0] result,
  output logic [NUM_CH-1:0]            wrap,
  output logic [NUM_CH-1:0]            err
);

  localparam int MW = DATA_WIDTH + 1;

  // Single conditional subtract: legal operands keep the sum below 2*M-1.
  // Returns {wrap, residue}.
  function automatic logic [MW-1:0] mod_reduce(input logic [MW-1:0] s,
                                               input logic [MW-1:0] m);
    if (s >= m) return {1'b1, DATA_WIDTH'(s - m)};
    else        return {1'b0, s[DATA_WIDTH-1:0]};
  endfunction

  logic [NUM_CH*DATA_WIDTH-1:0] a_p1, b_p1;
  logic [NUM_CH-1:0]            err_in, err_p1;
  logic                         vld_p1, mode_p1, clr_p1;
  logic [NUM_CH*DATA_WIDTH-1:0] res_p2;
  logic [NUM_CH-1:0]            wrap_p2;

  // ---- stage 1: capture operands, control and range checks ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      mode_p1 <= 1'b0;
      clr_p1  <= 1'b0;
    end else begin
      vld_p1  <= in_valid;
      mode_p1 <= op_mode;
      clr_p1  <= acc_clr;
    end
  end

  always_ff @(posedge clk) begin
    a_p1   <= a;
    b_p1   <= b;
    err_p1 <= err_in;
  end

  // ---- stage 2: per-channel modular sum and accumulator feedback ----
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [MW-1:0] MOD = MODULI[i*MW +: MW];

    logic [DATA_WIDTH-1:0] acc_q;
    logic [DATA_WIDTH-1:0] acc_base, opnd;
    logic [MW-1:0]         sum, red;

    assign err_in[i] = ({1'b0, a[i*DATA_WIDTH +: DATA_WIDTH]} >= MOD) |
                       (~op_mode & ({1'b0, b[i*DATA_WIDTH +: DATA_WIDTH]} >= MOD));

    // Clear takes effect before the add of the same beat.
    assign acc_base = clr_p1 ? '0 : acc_q;
    assign opnd     = mode_p1 ? acc_base : b_p1[i*DATA_WIDTH +: DATA_WIDTH];
    assign sum      = {1'b0, a_p1[i*DATA_WIDTH +: DATA_WIDTH]} + {1'b0, opnd};
    assign red      = mod_reduce(sum, MOD);

    assign res_p2[i*DATA_WIDTH +: DATA_WIDTH] = err_p1[i] ? '0 : red[DATA_WIDTH-1:0];
    assign wrap_p2[i] = ~err_p1[i] & red[DATA_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc_q <= '0;
      end else if (vld_p1 && mode_p1 && !err_p1[i]) begin
        acc_q <= res_p2[i*DATA_WIDTH +: DATA_WIDTH];
      end else if (clr_p1) begin
        acc_q <= '0;
      end
    end
  end

  // ---- output registers: hold on invalid cycles ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      wrap      <= '0;
      err       <= '0;
    end else begin
      out_valid <= vld_p1;
      if (vld_p1) begin
        result <= res_p2;
        wrap   <= wrap_p2;
        err    <= err_p1;
      end
    end
  end

endmodule

// File: tb/tb_rns_mod_add_acc.sv
// Randomised and directed bench for rns_mod_add_acc against an in-order arithmetic model.
module tb_rns_mod_add_acc;

  localparam int DW = 18;
  localparam int NC = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          op_mode = 1'b0;
  logic          acc_clr = 1'b0;
  logic [NC*DW-1:0] a = '0;
  logic [NC*DW-1:0] b = '0;
  logic          out_valid;
  logic [NC*DW-1:0] result;
  logic [NC-1:0] wrap;
  logic [NC-1:0] err;

  rns_mod_add_acc dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .op_mode(op_mode),
    .acc_clr(acc_clr), .a(a), .b(b), .out_valid(out_valid),
    .result(result), .wrap(wrap), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            vld;
    logic [NC*DW-1:0] res;
    logic [NC-1:0] wr;
    logic [NC-1:0] er;
  } exp_t;

  longint mods[NC] = '{177147, 262144, 130321, 161051};
  longint acc_m[NC];
  exp_t   q[$];
  logic [NC*DW-1:0] h_res;
  logic [NC-1:0]    h_wr, h_er;
  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NC*DW-1:0] pk(input int c0, input int c1, input int c2, input int c3);
    logic [NC*DW-1:0] v;
    v = {DW'(c3), DW'(c2), DW'(c1), DW'(c0)};
    return v;
  endfunction

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < NC; i++) acc_m[i] = 0;
    h_res = '0; h_wr = '0; h_er = '0;
  endtask

  // Model: modular arithmetic on plain integers, processed in beat order.
  task automatic model_beat(input bit v, input bit m, input bit c,
                            input logic [NC*DW-1:0] av, input logic [NC*DW-1:0] bv);
    exp_t e;
    longint ai, bi, base, s, r;
    bit er;
    e.vld = v; e.res = '0; e.wr = '0; e.er = '0;
    for (int i = 0; i < NC; i++) begin
      ai = longint'(av[i*DW +: DW]);
      bi = longint'(bv[i*DW +: DW]);
      if (v) begin
        er = (ai >= mods[i]) || (!m && bi >= mods[i]);
        base = m ? (c ? 0 : acc_m[i]) : bi;
        s = ai + base;
        r = er ? 0 : s % mods[i];
        e.er[i] = er;
        e.wr[i] = !er && (s >= mods[i]);
        e.res[i*DW +: DW] = DW'(r);
        if (m && !er) acc_m[i] = r;
        else if (c) acc_m[i] = 0;
      end else if (c) begin
        acc_m[i] = 0;
      end
    end
    q.push_back(e);
  endtask

  task automatic step(input bit v, input bit m, input bit c,
                      input logic [NC*DW-1:0] av, input logic [NC*DW-1:0] bv);
    exp_t e;
    bit ev;
    in_valid = v; op_mode = m; acc_clr = c; a = av; b = bv;
    model_beat(v, m, c, av, bv);
    @(posedge clk);
    #1;
    ev = 1'b0;
    if (q.size() == 2) begin
      e = q.pop_front();
      ev = e.vld;
      if (e.vld) begin
        h_res = e.res; h_wr = e.wr; h_er = e.er;
      end
    end
    chk("out_valid", out_valid, ev);
    chk("result", result, h_res);
    chk("wrap", wrap, h_wr);
    chk("err", err, h_er);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NC*DW-1:0] ra, rb;
    bit v, m, c;
    model_reset();
    #12;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_result", result, '0);
    chk("rst_wrap", wrap, '0);
    chk("rst_err", err, '0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD boundaries on ch0 and ch1
    step(1, 0, 0, pk(177140, 262143, 0, 0), pk(1, 1, 0, 0));
    step(1, 0, 0, pk(177140, 0, 0, 0), pk(7, 0, 0, 0));
    chk("add0_res", result[DW-1:0], 177141);
    chk("add1_res_pow2", result[2*DW-1:DW], 0);
    chk("add1_wrap_pow2", wrap[1], 1'b1);
    step(1, 0, 0, pk(177146, 0, 130320, 161050), pk(177146, 0, 130320, 161050));
    chk("add0_wrap_res", result[DW-1:0], 0);
    chk("add0_wrap", wrap[0], 1'b1);
    idle();
    chk("add_max_res", result[DW-1:0], 177145);
    chk("add_max_wrap", wrap, 4'b1101);

    // ACC back-to-back after a clear pulse
    step(0, 0, 1, '0, '0);
    step(1, 1, 0, pk(100000, 7, 0, 0), '0);
    step(1, 1, 0, pk(100000, 7, 0, 0), '0);
    chk("acc_b1", result[DW-1:0], 100000);
    step(1, 1, 0, pk(100000, 7, 0, 0), '0);
    chk("acc_b2", result[DW-1:0], 22853);
    chk("acc_b2_wrap", wrap[0], 1'b1);
    step(1, 1, 1, pk(5, 0, 0, 0), '0);
    chk("acc_b3", result[DW-1:0], 122853);
    chk("acc_b3_wrap", wrap[0], 1'b0);
    step(1, 0, 0, pk(1, 1, 1, 1), pk(2, 2, 2, 2));
    chk("acc_clr_add", result[DW-1:0], 5);
    step(1, 1, 0, pk(0, 0, 0, 0), '0);
    chk("add_after_clr", result[DW-1:0], 3);

    // Out-of-range operand on ch0 only
    step(1, 0, 0, pk(177147, 5, 6, 7), pk(0, 1, 2, 3));
    chk("acc_kept_5", result[DW-1:0], 5);
    step(1, 1, 0, pk(200000, 0, 0, 0), '0);
    chk("err_flag", err, 4'b0001);
    chk("err_res", result, pk(0, 6, 8, 10));
    chk("err_vld", out_valid, 1'b1);
    step(1, 1, 0, pk(0, 0, 0, 0), '0);
    chk("acc_err_flag", err[0], 1'b1);
    idle();
    chk("acc_after_err", result[DW-1:0], 5);
    idle();

    // Streaming sweep with random gaps, mode mix and a mid-stream reset
    for (int k = 0; k < 112; k++) begin
      for (int i = 0; i < NC; i++) begin
        ra[i*DW +: DW] = DW'((longint'(k) * k) % mods[i]);
        rb[i*DW +: DW] = DW'(longint'(k) % mods[i]);
      end
      v = ($urandom_range(0, 3) != 0);
      m = $urandom_range(0, 1) != 0;
      c = ($urandom_range(0, 9) == 0);
      step(v, m, c, ra, rb);
      if (k == 60) begin
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", out_valid, 1'b0);
        chk("mid_rst_res", result, '0);
        model_reset();
        #1 rst_n = 1'b1;
        step(1, 1, 0, pk(11, 22, 33, 44), '0);
        idle();
        chk("post_rst_acc", result, pk(11, 22, 33, 44));
      end
    end
    idle();
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
